// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder for the four rhythm-game lanes (A/S/D/F).
// Tracks held keys, suppresses typematic repeats and queues lane events behind valid/ready.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_done_tick,
    input  logic [7:0]                  rx_data,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [1:0]                  ev_lane,
    output logic                        ev_press,
    output logic [$clog2(FIFO_DEPTH):0] ev_count,
    output logic [3:0]                  held,
    output logic                        overflow
);

    localparam int PtrW = $clog2(FIFO_DEPTH);
    localparam int CntW = PtrW + 1;
    localparam int ToW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t          state;
    state_t          stateNext;
    logic [ToW-1:0]  idleCnt;
    logic [3:0]      heldNext;
    logic            emit;
    logic            emitPress;
    logic [2:0]      laneHit;
    logic [PtrW-1:0] rdPtr;
    logic [PtrW-1:0] wrPtr;
    logic            fifoFull;
    logic            pop;
    logic            accept;
    logic            drop;
    logic [2:0]      fifoMem [FIFO_DEPTH];

    // Returns {isLane, lane}.
    function automatic logic [2:0] laneOf(input logic [7:0] code);
        case (code)
            8'h1C:   laneOf = 3'b100;
            8'h1B:   laneOf = 3'b101;
            8'h23:   laneOf = 3'b110;
            8'h2B:   laneOf = 3'b111;
            default: laneOf = 3'b000;
        endcase
    endfunction

    always_comb begin
        stateNext = state;
        heldNext  = held;
        emit      = 1'b0;
        emitPress = 1'b0;
        laneHit   = laneOf(rx_data);
        if (rx_done_tick) begin
            unique case (state)
                IDLE: begin
                    if (rx_data == 8'hF0) begin
                        stateNext = BRK;
                    end else if (rx_data == 8'hE0) begin
                        stateNext = EXT;
                    end else if (laneHit[2] && !held[laneHit[1:0]]) begin
                        heldNext[laneHit[1:0]] = 1'b1;
                        emit      = 1'b1;
                        emitPress = 1'b1;
                    end
                end
                BRK: begin
                    if (laneHit[2]) begin
                        stateNext = IDLE;
                        if (held[laneHit[1:0]]) begin
                            heldNext[laneHit[1:0]] = 1'b0;
                            emit = 1'b1;
                        end
                    end else if (rx_data == 8'hE0) begin
                        stateNext = EXT;
                    end else if (rx_data != 8'hF0) begin
                        stateNext = IDLE;
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        stateNext = EXT_BRK;
                    end else if (rx_data != 8'hE0) begin
                        stateNext = IDLE;
                    end
                end
                EXT_BRK: stateNext = IDLE;
            endcase
        end else if (state != IDLE && idleCnt == ToW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon a prefix whose follow-up byte never arrived.
            stateNext = IDLE;
        end
    end

    assign fifoFull = (ev_count == CntW'(FIFO_DEPTH));
    assign pop      = ev_valid && ev_ready;
    assign accept   = emit && (!fifoFull || pop);
    assign drop     = emit && fifoFull && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idleCnt  <= '0;
            held     <= '0;
            overflow <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            ev_count <= '0;
        end else begin
            state <= stateNext;
            if (rx_done_tick || stateNext == IDLE) begin
                idleCnt <= '0;
            end else begin
                idleCnt <= idleCnt + ToW'(1);
            end
            held <= heldNext;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            if (accept && !pop) begin
                ev_count <= ev_count + CntW'(1);
            end else if (pop && !accept) begin
                ev_count <= ev_count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifoMem[wrPtr] <= {laneHit[1:0], emitPress};
        end
    end

    assign ev_valid = (ev_count != '0);
    assign ev_lane  = ev_valid ? fifoMem[rdPtr][2:1] : 2'd0;
    assign ev_press = ev_valid ? fifoMem[rdPtr][0] : 1'b0;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus randomized traffic against a prefix/queue reference model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;
    localparam int TO    = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [1:0] ev_lane;
    logic       ev_press;
    logic [2:0] ev_count;
    logic [3:0] held;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: pending-prefix flags, held bitmap, event queue (2*lane + press).
    int       mq[$];
    bit [3:0] mHeld;
    bit       mOvf, mExt, mBrk;
    int       mIdle;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_lane(ev_lane), .ev_press(ev_press),
        .ev_count(ev_count), .held(held), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int laneOf(input logic [7:0] b);
        case (b)
            8'h1C:   return 0;
            8'h1B:   return 1;
            8'h23:   return 2;
            8'h2B:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic doReset(input bit stb, input logic [7:0] d);
        reset = 1'b1; rx_done_tick = stb; rx_data = d; ev_ready = 1'b0;
        mq.delete(); mHeld = '0; mOvf = 0; mExt = 0; mBrk = 0; mIdle = 0;
        @(posedge clk); #1;
        reset = 1'b0; rx_done_tick = 1'b0;
    endtask

    task automatic tick(input bit stb, input logic [7:0] d, input bit rdy);
        int  L;
        int  ev = 0;
        bit  pop;
        bit  push = 0;
        rx_done_tick = stb; rx_data = d; ev_ready = rdy;
        pop = (mq.size() != 0) && rdy;
        if (stb) begin
            mIdle = 0;
            if (mExt && mBrk) begin
                mExt = 0; mBrk = 0;
            end else if (d == 8'hF0) begin
                mBrk = 1;
            end else if (d == 8'hE0) begin
                mExt = 1; mBrk = 0;
            end else begin
                L = laneOf(d);
                if (!mExt && L >= 0) begin
                    if (!mBrk && !mHeld[L]) begin mHeld[L] = 1; push = 1; ev = 2 * L + 1; end
                    else if (mBrk && mHeld[L]) begin mHeld[L] = 0; push = 1; ev = 2 * L; end
                end
                mExt = 0; mBrk = 0;
            end
        end else if (mExt || mBrk) begin
            mIdle++;
            if (mIdle >= TO) begin mExt = 0; mBrk = 0; mIdle = 0; end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else mOvf = 1;
        end
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic test_reset;
        doReset(0, 8'h00);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ev_valid); end
        checks++; if (ev_lane !== 2'd0) begin errors++; $display("FAIL rst_lane: got %0d want 0", ev_lane); end
        checks++; if (ev_press !== 1'b0) begin errors++; $display("FAIL rst_press: got %b want 0", ev_press); end
        checks++; if (ev_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", ev_count); end
        checks++; if (held !== 4'b0000) begin errors++; $display("FAIL rst_held: got %b want 0000", held); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_round_trip;
        tick(1, 8'h1C, 1);
        checks++; if ({ev_valid, ev_lane, ev_press} !== 4'b1001) begin errors++; $display("FAIL rt_make: got v%b l%0d p%b want v1 l0 p1", ev_valid, ev_lane, ev_press); end
        checks++; if (held !== 4'b0001) begin errors++; $display("FAIL rt_held1: got %b want 0001", held); end
        tick(1, 8'hF0, 1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rt_popped: got %b want 0", ev_valid); end
        tick(1, 8'h1C, 1);
        checks++; if ({ev_valid, ev_lane, ev_press} !== 4'b1000) begin errors++; $display("FAIL rt_break: got v%b l%0d p%b want v1 l0 p0", ev_valid, ev_lane, ev_press); end
        checks++; if (held !== 4'b0000) begin errors++; $display("FAIL rt_held0: got %b want 0000", held); end
        tick(0, 8'h00, 1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rt_empty: got %b want 0", ev_valid); end
    endtask

    task automatic test_typematic;
        for (int i = 0; i < 3; i++) begin
            tick(1, 8'h1B, 0);
            checks++; if (held !== 4'b0010 || ev_count !== 3'd1) begin errors++; $display("FAIL tm_repeat%0d: got held %b cnt %0d want 0010 cnt 1", i, held, ev_count); end
        end
        tick(1, 8'hF0, 0);
        tick(1, 8'h1B, 0);
        checks++; if (ev_count !== 3'd2 || held !== 4'b0000) begin errors++; $display("FAIL tm_after: got cnt %0d held %b want cnt 2 held 0000", ev_count, held); end
        checks++; if ({ev_valid, ev_lane, ev_press} !== 4'b1011) begin errors++; $display("FAIL tm_head0: got v%b l%0d p%b want v1 l1 p1", ev_valid, ev_lane, ev_press); end
        tick(0, 8'h00, 1);
        checks++; if ({ev_valid, ev_lane, ev_press} !== 4'b1010) begin errors++; $display("FAIL tm_head1: got v%b l%0d p%b want v1 l1 p0", ev_valid, ev_lane, ev_press); end
        tick(0, 8'h00, 1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL tm_empty: got %b want 0", ev_valid); end
    endtask

    task automatic test_ext_noise;
        logic [7:0] seq [9] = '{8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C, 8'hAA, 8'hFA, 8'hF0, 8'h5A};
        for (int i = 0; i < 9; i++) begin
            tick(1, seq[i], 1);
            checks++; if (ev_valid !== 1'b0 || held !== 4'b0000) begin errors++; $display("FAIL ext_noise%0d: got v%b held %b want v0 held 0000", i, ev_valid, held); end
        end
        tick(1, 8'h23, 0);
        checks++; if ({ev_valid, ev_lane, ev_press} !== 4'b1101 || held !== 4'b0100) begin errors++; $display("FAIL ext_d: got v%b l%0d p%b held %b want v1 l2 p1 held 0100", ev_valid, ev_lane, ev_press, held); end
        tick(1, 8'hF0, 1);
        tick(1, 8'h23, 1);
        tick(0, 8'h00, 1);
        checks++; if (ev_valid !== 1'b0 || held !== 4'b0000) begin errors++; $display("FAIL ext_drain: got v%b held %b want v0 held 0000", ev_valid, held); end
    endtask

    task automatic test_overflow;
        logic [7:0] seq [6] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0, 8'h2B};
        for (int i = 0; i < 6; i++) tick(1, seq[i], 0);
        checks++; if (ev_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", ev_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (held !== 4'b0111) begin errors++; $display("FAIL ovf_held: got %b want 0111", held); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev_valid !== 1'b1 || ev_lane !== 2'(i) || ev_press !== 1'b1) begin errors++; $display("FAIL ovf_head%0d: got v%b l%0d p%b want v1 l%0d p1", i, ev_valid, ev_lane, ev_press, i); end
            tick(0, 8'h00, 1);
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", ev_valid); end
    endtask

    task automatic test_full_push_pop;
        doReset(0, 8'h00);
        tick(1, 8'h1C, 0); tick(1, 8'h1B, 0); tick(1, 8'h23, 0); tick(1, 8'h2B, 0);
        checks++; if (ev_count !== 3'd4) begin errors++; $display("FAIL fpp_full: got %0d want 4", ev_count); end
        tick(1, 8'hF0, 0);
        tick(1, 8'h1C, 1);
        checks++; if (ev_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_both: got cnt %0d ovf %b want cnt 4 ovf 0", ev_count, overflow); end
        checks++; if (held !== 4'b1110 || ev_lane !== 2'd1 || ev_press !== 1'b1) begin errors++; $display("FAIL fpp_state: got held %b l%0d p%b want 1110 l1 p1", held, ev_lane, ev_press); end
    endtask

    task automatic test_timeout;
        doReset(0, 8'h00);
        tick(1, 8'hF0, 0);
        repeat (TO) tick(0, 8'h00, 0);
        tick(1, 8'h1C, 0);
        checks++; if (ev_count !== 3'd1 || {ev_lane, ev_press} !== 3'b001 || held !== 4'b0001) begin errors++; $display("FAIL to_fired: got cnt %0d l%0d p%b held %b want cnt 1 l0 p1 held 0001", ev_count, ev_lane, ev_press, held); end
        tick(1, 8'hF0, 0);
        repeat (TO - 1) tick(0, 8'h00, 0);
        tick(1, 8'h1C, 0);
        checks++; if (ev_count !== 3'd2 || held !== 4'b0000) begin errors++; $display("FAIL to_edge: got cnt %0d held %b want cnt 2 held 0000", ev_count, held); end
    endtask

    task automatic test_reset_queued;
        logic [7:0] seq [6] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0, 8'h2B};
        doReset(0, 8'h00);
        for (int i = 0; i < 6; i++) tick(1, seq[i], 0);
        tick(0, 8'h00, 1);
        checks++; if (ev_count !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL rq_pre: got cnt %0d ovf %b want cnt 3 ovf 1", ev_count, overflow); end
        doReset(1, 8'h1C);
        checks++; if (ev_count !== 3'd0 || held !== 4'b0000 || overflow !== 1'b0 || ev_valid !== 1'b0) begin errors++; $display("FAIL rq_post: got cnt %0d held %b ovf %b v%b want all 0", ev_count, held, overflow, ev_valid); end
        tick(0, 8'h00, 0);
        checks++; if (ev_valid !== 1'b0 || held !== 4'b0000) begin errors++; $display("FAIL rq_ignored: got v%b held %b want v0 held 0000", ev_valid, held); end
    endtask

    task automatic test_random;
        logic [7:0] pool [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0, 8'hE0, 8'hAA, 8'h5A};
        bit         stb, rdy, eV, eP;
        logic [1:0] eL;
        doReset(0, 8'h00);
        for (int i = 0; i < 800; i++) begin
            stb = ($urandom_range(0, 9) < 6);
            rdy = ((i % 200) < 70) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick(stb, pool[$urandom_range(0, 7)], rdy);
            eV = (mq.size() != 0);
            eL = eV ? 2'(mq[0] / 2) : 2'd0;
            eP = eV ? ((mq[0] % 2) == 1) : 1'b0;
            checks++; if ({ev_valid, ev_lane, ev_press} !== {eV, eL, eP}) begin errors++; $display("FAIL rnd_head@%0d: got v%b l%0d p%b want v%b l%0d p%b", i, ev_valid, ev_lane, ev_press, eV, eL, eP); end
            checks++; if (ev_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, ev_count, mq.size()); end
            checks++; if (held !== mHeld) begin errors++; $display("FAIL rnd_held@%0d: got %b want %b", i, held, mHeld); end
            checks++; if (overflow !== mOvf) begin errors++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, overflow, mOvf); end
        end
    endtask

    initial begin
        test_reset;
        test_round_trip;
        test_typematic;
        test_ext_noise;
        test_overflow;
        test_full_push_pop;
        test_timeout;
        test_reset_queued;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
